// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a shared combinational FPU, one operation in flight.
// Optional sticky status flags are enabled with `define FPU_ARB_STICKY_FLAGS_EN.
module fpu_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][31:0] req_op_a,
  input  logic [1:0][31:0] req_op_b,
  input  logic [1:0][2:0]  req_operation,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [31:0]      resp_result,
  output logic             resp_overflow,
  output logic             resp_underflow,
  output logic             resp_illegal,
  output logic [31:0]      fpu_op_a,
  output logic [31:0]      fpu_op_b,
  output logic [2:0]       fpu_operation,
  input  logic [31:0]      fpu_result,
  input  logic             fpu_overflow,
  input  logic             fpu_underflow
`ifdef FPU_ARB_STICKY_FLAGS_EN
  ,
  input  logic             sticky_clear,
  output logic             sticky_overflow,
  output logic             sticky_underflow
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic        gnt_q, gnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [31:0] res_q, res_d;
  logic        ovf_q, ovf_d, unf_q, unf_d, ill_q, ill_d;
  logic        grant_idx;
  logic        resp_hs;
`ifdef FPU_ARB_STICKY_FLAGS_EN
  logic        sticky_ovf_q, sticky_ovf_d, sticky_unf_q, sticky_unf_d;
`endif

  // rr_q remembers the requester served last; the other one wins a tie.
  always_comb begin
    grant_idx = req_valid[1];
    if (req_valid == 2'b11) grant_idx = ~rr_q;
  end

  assign resp_hs = (state_q == RESP) && resp_ready[gnt_q];

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    wait_cnt_d = wait_cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    opcode_d   = opcode_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    ill_d      = ill_q;
    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          gnt_d = grant_idx;
          if (req_operation[grant_idx][2]) begin
            state_d = RESP;
            res_d   = 32'd0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            ill_d   = 1'b1;
          end else begin
            state_d    = EXEC;
            op_a_d     = req_op_a[grant_idx];
            op_b_d     = req_op_b[grant_idx];
            opcode_d   = req_operation[grant_idx];
            wait_cnt_d = WAIT_LOAD;
            ill_d      = 1'b0;
          end
        end
      end
      EXEC: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = RESP;
          res_d   = fpu_result;
          ovf_d   = fpu_overflow;
          unf_d   = fpu_underflow;
          ill_d   = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_hs) begin
          state_d = IDLE;
          rr_d    = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FPU_ARB_STICKY_FLAGS_EN
  // Clear is applied after set so a same-cycle clear wins.
  always_comb begin
    sticky_ovf_d = sticky_ovf_q | (resp_hs & ovf_q);
    sticky_unf_d = sticky_unf_q | (resp_hs & unf_q);
    if (sticky_clear) begin
      sticky_ovf_d = 1'b0;
      sticky_unf_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b1;
      gnt_q      <= 1'b0;
      wait_cnt_q <= 4'd0;
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
      opcode_q   <= 3'd0;
      res_q      <= 32'd0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      ill_q      <= 1'b0;
`ifdef FPU_ARB_STICKY_FLAGS_EN
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      wait_cnt_q <= wait_cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      opcode_q   <= opcode_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      ill_q      <= ill_d;
`ifdef FPU_ARB_STICKY_FLAGS_EN
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
`endif
    end
  end

  // Outputs are forced quiet while rst is high, even before the first reset edge.
  assign req_ready      = (!rst && state_q == IDLE && req_valid != 2'b00) ?
                          (grant_idx ? 2'b10 : 2'b01) : 2'b00;
  assign resp_valid     = (!rst && state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_result    = rst ? 32'd0 : res_q;
  assign resp_overflow  = !rst && ovf_q;
  assign resp_underflow = !rst && unf_q;
  assign resp_illegal   = !rst && ill_q;
  assign fpu_op_a       = (!rst && state_q == EXEC) ? op_a_q : 32'd0;
  assign fpu_op_b       = (!rst && state_q == EXEC) ? op_b_q : 32'd0;
  assign fpu_operation  = (!rst && state_q == EXEC) ? opcode_q : 3'd0;
`ifdef FPU_ARB_STICKY_FLAGS_EN
  assign sticky_overflow  = sticky_ovf_q;
  assign sticky_underflow = sticky_unf_q;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter: directed commands push expected responses, a negedge monitor checks them.
// A small table-driven FPU stub answers the directed operand/opcode combinations.
module tb_fpu_arbiter;
  localparam int WAIT = 2;
  localparam int NV   = 8;

  typedef struct {
    logic        idx;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        ill;
    int          lat;
  } cmd_t;

  // Hand-computed single-precision results: 1+2, 3-1, 2*3, 6/2, max*max, min*min, 2+2, 1-2.
  localparam logic [2:0]  V_OP [NV] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd0, 3'd1};
  localparam logic [31:0] V_A  [NV] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40C00000,
                                        32'h7F000000, 32'h00800000, 32'h40000000, 32'h3F800000};
  localparam logic [31:0] V_B  [NV] = '{32'h40000000, 32'h3F800000, 32'h40400000, 32'h40000000,
                                        32'h7F000000, 32'h00800000, 32'h40000000, 32'h40000000};
  localparam logic [31:0] V_R  [NV] = '{32'h40400000, 32'h40000000, 32'h40C00000, 32'h40400000,
                                        32'h7F800000, 32'h00000000, 32'h40800000, 32'hBF800000};
  localparam logic        V_O  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic        V_U  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0][31:0] req_op_a, req_op_b;
  logic [1:0][2:0]  req_operation;
  logic [31:0]      resp_result, fpu_op_a, fpu_op_b, fpu_result;
  logic             resp_overflow, resp_underflow, resp_illegal;
  logic             fpu_overflow, fpu_underflow;
  logic [2:0]       fpu_operation;
`ifdef FPU_ARB_STICKY_FLAGS_EN
  logic             sticky_clear, sticky_overflow, sticky_underflow;
`endif

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  cmd_t q0[$];
  cmd_t q1[$];
  cmd_t sb[$];
  int   acc_cyc[$];
  logic acc_idx[$];

  fpu_arbiter #(.WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_operation(req_operation),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_overflow(resp_overflow),
    .resp_underflow(resp_underflow), .resp_illegal(resp_illegal),
    .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_operation(fpu_operation),
    .fpu_result(fpu_result), .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow)
`ifdef FPU_ARB_STICKY_FLAGS_EN
    ,
    .sticky_clear(sticky_clear), .sticky_overflow(sticky_overflow),
    .sticky_underflow(sticky_underflow)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    fpu_result    = 32'hDEADBEEF;
    fpu_overflow  = 1'b0;
    fpu_underflow = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (fpu_operation == V_OP[i] && fpu_op_a == V_A[i] && fpu_op_b == V_B[i]) begin
        fpu_result    = V_R[i];
        fpu_overflow  = V_O[i];
        fpu_underflow = V_U[i];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_vec(input logic idx, input int v);
    cmd_t c;
    c.idx = idx; c.op = V_OP[v]; c.a = V_A[v]; c.b = V_B[v];
    c.res = V_R[v]; c.ovf = V_O[v]; c.unf = V_U[v]; c.ill = 1'b0; c.lat = WAIT + 1;
    if (idx) q1.push_back(c); else q0.push_back(c);
  endtask

  task automatic add_ill(input logic idx, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    cmd_t c;
    c.idx = idx; c.op = op; c.a = a; c.b = b;
    c.res = 32'd0; c.ovf = 1'b0; c.unf = 1'b0; c.ill = 1'b1; c.lat = 1;
    if (idx) q1.push_back(c); else q0.push_back(c);
  endtask

  // Drive the next queued command on requester i and record its expected response.
  task automatic load(input logic i);
    cmd_t c;
    if ((i == 1'b0 && q0.size() == 0) || (i == 1'b1 && q1.size() == 0)) begin
      req_valid[i] = 1'b0;
    end else begin
      c = i ? q1.pop_front() : q0.pop_front();
      req_valid[i]     = 1'b1;
      req_op_a[i]      = c.a;
      req_op_b[i]      = c.b;
      req_operation[i] = c.op;
      sb.push_back(c);
    end
  endtask

  task automatic run_cmds();
    logic [1:0] acc;
    int n = 0;
    if (!req_valid[0]) load(1'b0);
    if (!req_valid[1]) load(1'b1);
    while (req_valid != 2'b00 && n < 200) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      if (acc[0]) load(1'b0);
      if (acc[1]) load(1'b1);
      n++;
    end
    check("all_accepted", 32'(req_valid), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || resp_valid != 2'b00) && n < 100);
    check("drain_pending", 32'(sb.size()) + 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on each new response and checks it every cycle it is held.
  initial begin
    cmd_t       cur;
    logic [1:0] prev_rv = 2'b00;
    logic [1:0] exp_rv;
    int         ac;
    logic       ai;
    cur.idx = 1'b0; cur.res = '0; cur.ovf = 1'b0; cur.unf = 1'b0; cur.ill = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_cyc.delete();
        acc_idx.delete();
        prev_rv = 2'b00;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_resp_flags", {29'd0, resp_overflow, resp_underflow, resp_illegal}, 32'd0);
        check("rst_fpu", fpu_op_a | fpu_op_b | 32'(fpu_operation), 32'd0);
      end else begin
        if ((req_valid & req_ready) != 2'b00) begin
          acc_cyc.push_back(cyc);
          acc_idx.push_back(req_ready[1]);
          check("accept_onehot", 32'(req_ready == 2'b01 || req_ready == 2'b10), 32'd1);
        end
        if (req_valid == 2'b00) check("ready_without_valid", 32'(req_ready), 32'd0);
        if (req_ready != 2'b00) begin
          check("idle_fpu_a", fpu_op_a, 32'd0);
          check("idle_fpu_b", fpu_op_b, 32'd0);
          check("idle_fpu_op", 32'(fpu_operation), 32'd0);
        end
        if (resp_valid != 2'b00) begin
          check("busy_req_ready", 32'(req_ready), 32'd0);
          if (prev_rv == 2'b00) begin
            if (sb.size() == 0 || acc_cyc.size() == 0) begin
              check("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
              cur = sb.pop_front();
              ac  = acc_cyc.pop_front();
              ai  = acc_idx.pop_front();
              check("accept_idx", 32'(ai), 32'(cur.idx));
              check("latency", 32'(cyc - ac), 32'(cur.lat));
            end
          end
          exp_rv = cur.idx ? 2'b10 : 2'b01;
          check("resp_valid", 32'(resp_valid), 32'(exp_rv));
          check("resp_result", resp_result, cur.res);
          check("resp_flags", {29'd0, resp_overflow, resp_underflow, resp_illegal},
                {29'd0, cur.ovf, cur.unf, cur.ill});
          if (cur.ill) check("illegal_fpu", fpu_op_a | fpu_op_b | 32'(fpu_operation), 32'd0);
        end
        prev_rv = resp_valid;
      end
    end
  end

  initial begin
    int   n;
    logic got;
    rst           = 1'b1;
    req_valid     = 2'b00;
    req_op_a      = '0;
    req_op_b      = '0;
    req_operation = '0;
    resp_ready    = 2'b11;
`ifdef FPU_ARB_STICKY_FLAGS_EN
    sticky_clear  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 32'(req_ready), 32'd0);
    check("post_reset_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;

    // Single ADD on requester 0: 1.0 + 2.0.
    add_vec(1'b0, 0);
    run_cmds();
    wait_idle();

    // Contention from reset: expected order SUB(r0), DIV(r1), MUL(r0), ADD(r1).
    do_reset();
    add_vec(1'b0, 1); add_vec(1'b0, 2);
    add_vec(1'b1, 3); add_vec(1'b1, 6);
    run_cmds();
    wait_idle();

    // Backpressure with only the non-granted ready bit high; requester 1 waits meanwhile.
    resp_ready = 2'b10;
    add_vec(1'b0, 2);
    run_cmds();
    n = 0;
    while (resp_valid == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_resp_seen", 32'(resp_valid), 32'h1);
    @(posedge clk); #1;
    add_vec(1'b1, 3);
    load(1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(resp_valid), 32'h1);
      check("bp_hold_result", resp_result, 32'h40C00000);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 2'b11;
    run_cmds();
    wait_idle();

    // Illegal opcodes go straight to a response.
    add_ill(1'b1, 3'b100, 32'h3F800000, 32'h40000000);
    run_cmds();
    wait_idle();
    add_ill(1'b0, 3'b111, 32'h40000000, 32'h40400000);
    run_cmds();
    wait_idle();

    // Overflow then underflow.
    add_vec(1'b0, 4);
    run_cmds();
    wait_idle();
`ifdef FPU_ARB_STICKY_FLAGS_EN
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sticky_ovf_set", 32'(sticky_overflow), 32'd1);
    check("sticky_unf_clear", 32'(sticky_underflow), 32'd0);
    @(posedge clk); #1;
`endif
    add_vec(1'b1, 5);
    run_cmds();
    wait_idle();
`ifdef FPU_ARB_STICKY_FLAGS_EN
    @(negedge clk);
    check("sticky_ovf_kept", 32'(sticky_overflow), 32'd1);
    check("sticky_unf_set", 32'(sticky_underflow), 32'd1);
    @(posedge clk); #1 sticky_clear = 1'b1;
    @(posedge clk); #1 sticky_clear = 1'b0;
    @(negedge clk);
    check("sticky_cleared", 32'({sticky_overflow, sticky_underflow}), 32'd0);
    @(posedge clk); #1;
`endif

    // Serve requester 0 so the pointer favours 1, then abort a requester-1 op mid-EXEC.
    add_vec(1'b0, 0);
    run_cmds();
    wait_idle();
    req_valid[1]     = 1'b1;
    req_op_a[1]      = 32'h3F800000;
    req_op_b[1]      = 32'h40000000;
    req_operation[1] = 3'd1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = req_ready[1];
      n++;
    end
    check("abort_accepted", 32'(got), 32'd1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(posedge clk); #1;
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    add_vec(1'b0, 6);
    add_vec(1'b1, 7);
    run_cmds();
    wait_idle();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, sets the number of cycles operands are held on the FPU before the result is sampled (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req_valid  input  [1:0]  per-requester command valid.
REQ-005 req_ready  output  [1:0]  per-requester command accept; a transfer occurs when valid and ready are both high.
REQ-006 req_op_a, req_op_b  input  [1:0][31:0]  per-requester single-precision operands.
REQ-007 req_operation  input  [1:0][2:0]  per-requester opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV; 100-111 are illegal.
REQ-008 resp_valid  output  [1:0]  per-requester response valid.
REQ-009 resp_ready  input  [1:0]  per-requester response accept.
REQ-010 resp_result  output  32  result of the granted operation.
REQ-011 resp_overflow, resp_underflow, resp_illegal  output  1 each  status of the granted operation.
REQ-012 fpu_op_a, fpu_op_b  output  32  operands driven to the combinational FPU.
REQ-013 fpu_operation  output  3  opcode driven to the FPU.
REQ-014 fpu_result  input  32  FPU result.
REQ-015 fpu_overflow, fpu_underflow  input  1 each  FPU flags.

Function
REQ-016 FSM states: IDLE, EXEC, RESP.
REQ-017 IDLE: req_ready is one-hot to the granted requester and zero when no request is valid.
REQ-018 Arbitration is round-robin: with both requesters valid, the grant goes to the requester not served last; after reset requester 0 has priority.
REQ-019 On accept of a legal opcode: operands and opcode are registered, the grant index (gnt) is stored, wait_cnt loads WAIT_CYCLES-1, and the FSM moves IDLE->EXEC.
REQ-020 EXEC: fpu_op_a, fpu_op_b and fpu_operation hold the registered values stable; wait_cnt decrements each cycle.
REQ-021 EXEC with wait_cnt==0: fpu_result, fpu_overflow and fpu_underflow are captured into the resp_* registers, and the FSM moves to RESP.
REQ-022 Accept-to-resp_valid latency is WAIT_CYCLES+1 cycles.
REQ-023 On accept of an illegal opcode (100-111): the FSM goes IDLE->RESP directly with resp_result=0, resp_illegal=1, resp_overflow=0 and resp_underflow=0; the FPU is not exercised.
REQ-024 RESP: resp_valid[gnt]=1 and the other bit is 0; resp_* values hold stable until resp_ready[gnt]=1.
REQ-025 The FSM leaves RESP for IDLE on the resp handshake, the round-robin pointer updates to gnt, and resp_valid drops in the next cycle.
REQ-026 Outside IDLE, req_ready=2'b00; new requests are never accepted while an operation is in flight (single outstanding operation).
REQ-027 In IDLE and after reset, fpu_* outputs drive zero operands with opcode 000.
REQ-028 resp_ready on the non-granted bit is ignored.
REQ-029 req_valid deasserting before the grant is legal; the request is then simply not accepted.

Reset
REQ-030 With rst=1 at a clock edge: FSM=IDLE, round-robin pointer=1 (so requester 0 wins first), wait_cnt=0, and all registered operands and responses are 0.
REQ-031 Under reset, req_ready=0, resp_valid=0, resp_result=0, all resp flags=0 and fpu_* outputs=0.
REQ-032 Reset asserted in EXEC or RESP abandons the operation without emitting a response.

Configuration
REQ-033 Macro FPU_ARB_STICKY_FLAGS_EN adds outputs sticky_overflow and sticky_underflow (1 bit each) and input sticky_clear (1 bit).
REQ-034 With FPU_ARB_STICKY_FLAGS_EN, each sticky flag sets on any completed response with the corresponding flag high and stays set until sticky_clear=1 or rst=1; if set and clear occur in the same cycle, clear wins.
REQ-035 Without FPU_ARB_STICKY_FLAGS_EN, these ports and their registers do not exist, and all other behaviour is identical.

Verification
REQ-036 Single request: requester 0 sends ADD with 0x3F800000 and 0x40000000, WAIT_CYCLES=2 -> resp_valid[0] 3 cycles after accept with resp_result=0x40400000 and all flags 0.
REQ-037 Contention: both requesters valid continuously after reset -> grants alternate 0,1,0,1, with each response returned to the correct resp_valid bit.
REQ-038 Backpressure: resp_ready held 0 for 5 cycles in RESP -> resp_result and resp_valid stay stable, and req_ready stays 00.
REQ-039 Illegal opcode 100 -> resp_valid 1 cycle after accept with resp_illegal=1 and resp_result=0; fpu_* outputs remain 0.
REQ-040 Overflow: MUL of 0x7F000000 by 0x7F000000 -> resp_overflow=1; with FPU_ARB_STICKY_FLAGS_EN, sticky_overflow stays 1 until sticky_clear=1.
REQ-041 Reset mid-EXEC -> no response is emitted, and the next request is granted to requester 0 first.
